conv_result_fifo: RTL and testbench

- Downstream stage of the Wishbone convolution-engine wrapper. Captures each result pair {outb, outa} on a valid strobe and stores it in a small synchronous FIFO.
- Exposes the FIFO to the Wishbone host through a pop register, a status register, a control register and a threshold register, so results are not lost between host polls.
- Drives a level interrupt when the FIFO holds at least the programmed number of entries.

---
 rtl/conv_acc_pkg.sv | 41 ++++
 rtl/res_sync_fifo.sv | 64 ++++++
 rtl/conv_result_fifo.sv | 148 ++++++++++++++
 tb/tb_conv_result_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_acc_pkg.sv
// Shared constants for the convolution-engine result path: register addresses,
// STATUS/CTRL bit positions and the register decode helper. Build option: RESULT_RELU_EN.
package conv_acc_pkg;

    localparam logic [3:0] ADDR_RES_PAGE = 4'hB;
    localparam logic [7:0] ADDR_RES_POP  = 8'hB0;
    localparam logic [7:0] ADDR_RES_STAT = 8'hB1;
    localparam logic [7:0] ADDR_RES_CTRL = 8'hB2;
    localparam logic [7:0] ADDR_RES_THR  = 8'hB3;

    localparam int STAT_OVF   = 8;
    localparam int STAT_CLAMP = 9;
`ifdef RESULT_RELU_EN
    // Clamp flag takes bit 9, so underflow shifts up one place.
    localparam int STAT_UNF   = 10;
`else
    localparam int STAT_UNF   = 9;
`endif

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [2:0] {
        REG_POP,
        REG_STAT,
        REG_CTRL,
        REG_THR,
        REG_NONE
    } res_reg_e;

    function automatic res_reg_e reg_decode(input logic [7:0] a);
        case (a)
            ADDR_RES_POP:  return REG_POP;
            ADDR_RES_STAT: return REG_STAT;
            ADDR_RES_CTRL: return REG_CTRL;
            ADDR_RES_THR:  return REG_THR;
            default:       return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/res_sync_fifo.sv
// Synchronous result FIFO: storage, wrapping pointers, occupancy and full/empty.
// Flush beats both push and pop; a pop at full frees the slot for a same-edge push.
module res_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   level,
    output logic [AW:0]   level_next,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign rdata   = mem[rptr];

    always_comb begin
        level_next = level;
        if (flush)
            level_next = '0;
        else if (do_push & ~do_pop)
            level_next = level + 1'b1;
        else if (do_pop & ~do_push)
            level_next = level - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            level <= level_next;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + 1'b1;
                if (do_pop)  rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/conv_result_fifo.sv
// Result capture FIFO behind the Wishbone wrapper: pop/status/ctrl/threshold registers
// and a level interrupt. Build option RESULT_RELU_EN clamps negative results to zero.
module conv_result_fifo
    import conv_acc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int RES_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic [RES_W-1:0] outa,
    input  logic [RES_W-1:0] outb,
    input  logic             cyc,
    input  logic             str,
    input  logic             we,
    input  logic [7:0]       addr,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    output logic             ack,
    output logic             irq,
    output logic             full,
    output logic             empty
);

    res_reg_e             rsel;
    logic                 sel;
    logic                 take;
    logic                 rd_pop;
    logic                 wr_ctrl;
    logic                 wr_thr;
    logic                 flush;
    logic                 ovf_hit;
    logic                 unf_hit;
    logic                 ovf;
    logic                 unf;
    logic                 irq_en;
    logic [AW:0]          thr;
    logic [AW:0]          level;
    logic [AW:0]          level_next;
    logic [2*RES_W-1:0]   head;
    logic [RES_W-1:0]     val_a;
    logic [RES_W-1:0]     val_b;
    logic [31:0]          status;
    logic [31:0]          rd_data;
    logic                 data_unused;

    assign data_unused = ^data_in[31:AW+1];

    // Side effects fire only on the edge where ack rises, so a held request acts once.
    assign sel     = cyc & str & (addr[7:4] == ADDR_RES_PAGE);
    assign take    = sel & ~ack;
    assign rsel    = reg_decode(addr);
    assign rd_pop  = take & ~we & (rsel == REG_POP);
    assign wr_ctrl = take & we & (rsel == REG_CTRL);
    assign wr_thr  = take & we & (rsel == REG_THR);
    assign flush   = wr_ctrl & data_in[CTRL_FLUSH];
    assign unf_hit = rd_pop & empty;
    assign ovf_hit = res_valid & ~flush & full & ~rd_pop;

`ifdef RESULT_RELU_EN
    logic clamp;
    logic clamp_hit;

    assign val_a     = outa[RES_W-1] ? '0 : outa;
    assign val_b     = outb[RES_W-1] ? '0 : outb;
    assign clamp_hit = res_valid & ~flush & (~full | rd_pop) & (outa[RES_W-1] | outb[RES_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            clamp <= 1'b0;
        else if (flush)
            clamp <= 1'b0;
        else if (clamp_hit)
            clamp <= 1'b1;
    end
`else
    assign val_a = outa;
    assign val_b = outb;
`endif

    res_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (2*RES_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (res_valid),
        .pop        (rd_pop),
        .wdata      ({val_b, val_a}),
        .rdata      (head),
        .level      (level),
        .level_next (level_next),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        status           = '0;
        status[4:0]      = 5'(level);
        status[STAT_OVF] = ovf;
        status[STAT_UNF] = unf;
`ifdef RESULT_RELU_EN
        status[STAT_CLAMP] = clamp;
`endif
    end

    always_comb begin
        rd_data = '0;
        case (rsel)
            REG_POP:  if (!empty) rd_data = 32'(head);
            REG_STAT: rd_data = status;
            REG_CTRL: rd_data[CTRL_IRQ_EN] = irq_en;
            REG_THR:  rd_data = 32'(thr);
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack      <= 1'b0;
            data_out <= '0;
            irq      <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            irq_en   <= 1'b0;
            thr      <= '0;
        end else begin
            ack      <= take;
            data_out <= (take & ~we) ? rd_data : '0;
            if (flush) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                if (ovf_hit) ovf <= 1'b1;
                if (unf_hit) unf <= 1'b1;
            end
            if (wr_ctrl) irq_en <= data_in[CTRL_IRQ_EN];
            if (wr_thr)  thr    <= data_in[AW:0];
            // Threshold of zero means the interrupt is disarmed.
            irq <= irq_en & (thr != '0) & (level_next >= thr);
        end
    end

endmodule

// File: tb/tb_conv_result_fifo.sv
// Directed plus randomized bench for conv_result_fifo against a queue-based model.
// Also tracks the RESULT_RELU_EN clamp behaviour when that macro is defined.
module tb_conv_result_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0;
    logic [15:0] outa = '0;
    logic [15:0] outb = '0;
    logic        cyc = 1'b0;
    logic        str = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        ack;
    logic        irq;
    logic        full;
    logic        empty;

    int total = 0;
    int bad = 0;

    logic [31:0] q[$];
    bit          ovf_m, unf_m, clamp_m, irq_en_m, ack_m, irq_m;
    logic [4:0]  thr_m;
    logic [31:0] dout_m;
    logic [7:0]  addrs [7] = '{8'hB0, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB7, 8'hA0};

`ifdef RESULT_RELU_EN
    localparam int UNF_B = 10;
`else
    localparam int UNF_B = 9;
`endif

    conv_result_fifo dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .outa(outa), .outb(outb),
        .cyc(cyc), .str(str), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ack(ack), .irq(irq), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[4:0] = 5'(q.size());
        s[8] = ovf_m;
        s[UNF_B] = unf_m;
`ifdef RESULT_RELU_EN
        s[9] = clamp_m;
`endif
        return s;
    endfunction

    task automatic m_reset();
        q.delete();
        ovf_m = 0; unf_m = 0; clamp_m = 0; irq_en_m = 0;
        ack_m = 0; irq_m = 0; thr_m = '0; dout_m = '0;
    endtask

    // Predict one clock edge from the current inputs, advance, then compare outputs.
    task automatic tick();
        bit sel, take, popped, en_old;
        int n;
        logic [31:0] rd, wv;
        logic [4:0] thr_old;
        sel = cyc && str && (addr[7:4] == 4'hB);
        take = sel && !ack_m;
        n = q.size();
        en_old = irq_en_m;
        thr_old = thr_m;
        rd = '0;
        if (take && !we) begin
            case (addr)
                8'hB0: rd = (n > 0) ? q[0] : 32'h0;
                8'hB1: rd = m_status();
                8'hB2: rd = {30'b0, irq_en_m, 1'b0};
                8'hB3: rd = {27'b0, thr_m};
                default: rd = '0;
            endcase
        end
        wv = {outb, outa};
`ifdef RESULT_RELU_EN
        if (wv[15]) wv[15:0] = '0;
        if (wv[31]) wv[31:16] = '0;
`endif
        if (take && we && addr == 8'hB2 && data_in[0]) begin
            q.delete();
            ovf_m = 0; unf_m = 0; clamp_m = 0;
        end else begin
            popped = take && !we && addr == 8'hB0 && n > 0;
            if (take && !we && addr == 8'hB0 && n == 0) unf_m = 1;
            if (popped) void'(q.pop_front());
            if (res_valid) begin
                if (n == 16 && !popped) ovf_m = 1;
                else begin
                    q.push_back(wv);
                    if (outa[15] || outb[15]) clamp_m = 1;
                end
            end
        end
        if (take && we && addr == 8'hB2) irq_en_m = data_in[1];
        if (take && we && addr == 8'hB3) thr_m = data_in[4:0];
        irq_m = en_old && thr_old != 0 && q.size() >= int'(thr_old);
        ack_m = take;
        dout_m = rd;
        @(posedge clk); #1;
        chk("ack", {31'b0, ack}, {31'b0, ack_m});
        chk("data_out", data_out, dout_m);
        chk("irq", {31'b0, irq}, {31'b0, irq_m});
        chk("full", {31'b0, full}, {31'b0, q.size() == 16});
        chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    endtask

    task automatic push(input logic [31:0] d);
        outa = d[15:0]; outb = d[31:16]; res_valid = 1;
        tick();
        res_valid = 0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] v);
        cyc = 1; str = 1; we = 0; addr = a;
        tick();
        v = data_out;
        cyc = 0; str = 0; res_valid = 0;
        tick();
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        cyc = 1; str = 1; we = 1; addr = a; data_in = d;
        tick();
        cyc = 0; str = 0; we = 0; res_valid = 0;
        tick();
    endtask

    initial begin
        logic [31:0] v, last;
        int hold;
        m_reset();
        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_full", {31'b0, full}, 32'h0);
        chk("rst_empty", {31'b0, empty}, 32'h1);
        @(posedge clk); #1;
        rst = 0;

        // In-order pops of three results
        push(32'h0001_0002); push(32'h0003_0004); push(32'h0005_0006);
        bus_rd(8'hB1, v); chk("stat_lvl3", v, 32'h3);
        bus_rd(8'hB0, v); chk("pop0", v, 32'h0001_0002);
        bus_rd(8'hB0, v); chk("pop1", v, 32'h0003_0004);
        bus_rd(8'hB0, v); chk("pop2", v, 32'h0005_0006);
        bus_rd(8'hB1, v); chk("stat_lvl0", v, 32'h0);

        // Overfill by one
        for (int i = 0; i < 16; i++) push($urandom);
        chk("full16", {31'b0, full}, 32'h1);
        push($urandom);
        bus_rd(8'hB1, v); chk("stat_ovf", v, 32'h110);

        // Flush, refill, then pop and push on the same edge at full
        bus_wr(8'hB2, 32'h1);
        bus_rd(8'hB1, v); chk("stat_flushed", v, 32'h0);
        for (int i = 0; i < 16; i++) push({16'h0100 + 16'(i), 16'h0200 + 16'(i)});
        res_valid = 1; outa = 16'h7EEF; outb = 16'h1BAD;
        bus_rd(8'hB0, v); chk("pop_at_full", v, 32'h0100_0200);
        bus_rd(8'hB1, v); chk("stat_full_no_ovf", v, 32'h010);
        for (int i = 0; i < 16; i++) bus_rd(8'hB0, last);
        chk("new_entry_last", last, 32'h1BAD_7EEF);

        // Underflow
        bus_rd(8'hB0, v); chk("underflow_data", v, 32'h0);
        bus_rd(8'hB1, v); chk("stat_unf", v, 32'h1 << UNF_B);

        // Threshold interrupt
        bus_wr(8'hB3, 32'h4);
        bus_wr(8'hB2, 32'h2);
        bus_rd(8'hB2, v); chk("ctrl_rd", v, 32'h2);
        bus_rd(8'hB3, v); chk("thr_rd", v, 32'h4);
        for (int i = 0; i < 3; i++) push($urandom);
        chk("irq_below", {31'b0, irq}, 32'h0);
        push($urandom);
        chk("irq_at_thr", {31'b0, irq}, 32'h1);
        cyc = 1; str = 1; we = 0; addr = 8'hB0;
        tick();
        chk("irq_drop", {31'b0, irq}, 32'h0);
        cyc = 0; str = 0; tick();

        // Flush beats a same-edge push
        res_valid = 1; outa = 16'h1111; outb = 16'h2222;
        bus_wr(8'hB2, 32'h1);
        bus_rd(8'hB1, v); chk("flush_wins", v, 32'h0);

        // Held request: acknowledged every other cycle
        cyc = 1; str = 1; we = 0; addr = 8'hB1;
        for (int i = 0; i < 4; i++) tick();
        cyc = 0; str = 0; tick();

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            res_valid = ($urandom_range(0, 99) < 45);
            outa = 16'($urandom);
            outb = 16'($urandom);
            if (hold == 0) begin
                hold = $urandom_range(1, 3);
                cyc = ($urandom_range(0, 2) != 0);
                str = ($urandom_range(0, 5) != 0);
                addr = addrs[$urandom_range(0, 6)];
                we = (addr == 8'hB2 || addr == 8'hB3 || addr == 8'hB7) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (addr == 8'hB3) data_in = 32'($urandom_range(0, 20));
                else data_in = {$urandom, 1'b0} | 32'($urandom_range(0, 9) == 0);
            end
            hold--;
            tick();
        end
        cyc = 0; str = 0; res_valid = 0; tick();

        // Reset in the middle of a transaction
        cyc = 1; str = 1; we = 0; addr = 8'hB1;
        rst = 1;
        #1;
        chk("midrst_ack_async", {31'b0, ack}, 32'h0);
        @(posedge clk); #1;
        chk("midrst_ack", {31'b0, ack}, 32'h0);
        chk("midrst_data", data_out, 32'h0);
        chk("midrst_empty", {31'b0, empty}, 32'h1);
        cyc = 0; str = 0;
        rst = 0;
        m_reset();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
